reduce_nway_pipe: RTL and testbench

- Pipelined, parametrised N-input bitwise reduction unit (OR / AND / XOR selectable per transaction).
- Successor to the fixed 8-way OR tree: generic width, registered tree levels, valid/ready handshake at both ends.
- Used wherever wide flag vectors (interrupt pending, error summary, parity) must be reduced at full clock rate without a long combinational path.

---
 rtl/reduce_nway_pipe_if.sv | 37 +++
 rtl/reduce_nway_pipe.sv | 153 +++++++++++++++
 tb/tb_reduce_nway_pipe.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reduce_nway_pipe_if.sv
// Handshake bundle for reduce_nway_pipe: input beat side and reduced output side.
// REDUCE_NWAY_ACCUM_EN adds the in_last frame marker.
interface reduce_nway_pipe_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
`ifdef REDUCE_NWAY_ACCUM_EN
  logic             in_last;
`endif
  logic             out;
  logic [1:0]       out_mode;
  logic             out_valid;
  logic             out_ready;

`ifdef REDUCE_NWAY_ACCUM_EN
  modport slave (
    input  in, mode, in_valid, in_last, out_ready,
    output in_ready, out, out_mode, out_valid
  );
  modport master (
    output in, mode, in_valid, in_last, out_ready,
    input  in_ready, out, out_mode, out_valid
  );
`else
  modport slave (
    input  in, mode, in_valid, out_ready,
    output in_ready, out, out_mode, out_valid
  );
  modport master (
    output in, mode, in_valid, out_ready,
    input  in_ready, out, out_mode, out_valid
  );
`endif
endinterface

// File: rtl/reduce_nway_pipe.sv
// Pipelined N-input OR/AND/XOR reduction tree, one registered level per tree stage, global stall.
// Optional frame accumulation across beats is enabled with REDUCE_NWAY_ACCUM_EN.
module reduce_nway_pipe #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  reduce_nway_pipe_if.slave bus
);
  localparam int LEVELS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
  localparam int PAD    = 1 << LEVELS;
  localparam int HALF   = PAD / 2;

  function automatic logic op(input logic a, input logic b, input logic [1:0] m);
    case (m)
      2'b01:   op = a & b;
      2'b10:   op = a ^ b;
      default: op = a | b;
    endcase
  endfunction

  logic            stall;
  logic            accept;
  logic [1:0]      in_mode_eff;
  logic [PAD-1:0]  pad_data;
  logic [HALF-1:0] data_reg  [1:LEVELS];
  logic            valid_reg [1:LEVELS];
  logic [1:0]      mode_reg  [1:LEVELS];
`ifdef REDUCE_NWAY_ACCUM_EN
  logic            last_reg  [1:LEVELS];
  logic            frame_open_reg;
  logic [1:0]      frame_mode_reg;
  logic            acc_open_reg;
  logic            acc_reg;
  logic            folded;
`endif

  assign bus.in_ready = rst_n && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef REDUCE_NWAY_ACCUM_EN
  // Later beats of a frame are reduced with the mode latched from the frame's first beat.
  assign in_mode_eff = frame_open_reg ? frame_mode_reg : bus.mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_open_reg <= 1'b0;
      frame_mode_reg <= 2'b00;
    end else if (accept) begin
      if (bus.in_last) begin
        frame_open_reg <= 1'b0;
      end else if (!frame_open_reg) begin
        frame_open_reg <= 1'b1;
        frame_mode_reg <= bus.mode;
      end
    end
  end
`else
  assign in_mode_eff = bus.mode;
`endif

  // Pad up to a power of two with the identity of the selected operation.
  always_comb begin
    pad_data              = {PAD{in_mode_eff == 2'b01}};
    pad_data[WIDTH-1:0]   = bus.in;
  end

  genvar gi;
  generate
    for (gi = 1; gi <= LEVELS; gi++) begin : gen_lvl
      logic [PAD-1:0]  prev_data;
      logic            prev_valid;
      logic [1:0]      prev_mode;
      logic [HALF-1:0] next_data;
`ifdef REDUCE_NWAY_ACCUM_EN
      logic            prev_last;
`endif

      if (gi == 1) begin : gen_first
        assign prev_data  = pad_data;
        assign prev_valid = accept;
        assign prev_mode  = in_mode_eff;
`ifdef REDUCE_NWAY_ACCUM_EN
        assign prev_last  = bus.in_last;
`endif
      end else begin : gen_inner
        // Bits above the live width of this level are don't-care and never reach bit 0.
        assign prev_data  = {{HALF{1'b0}}, data_reg[gi-1]};
        assign prev_valid = valid_reg[gi-1];
        assign prev_mode  = mode_reg[gi-1];
`ifdef REDUCE_NWAY_ACCUM_EN
        assign prev_last  = last_reg[gi-1];
`endif
      end

      always_comb begin
        next_data = '0;
        for (int j = 0; j < HALF; j++) begin
          next_data[j] = op(prev_data[2*j], prev_data[2*j+1], prev_mode);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
          mode_reg[gi]  <= 2'b00;
`ifdef REDUCE_NWAY_ACCUM_EN
          last_reg[gi]  <= 1'b0;
`endif
        end else if (!stall) begin
          data_reg[gi]  <= next_data;
          valid_reg[gi] <= prev_valid;
          mode_reg[gi]  <= prev_mode;
`ifdef REDUCE_NWAY_ACCUM_EN
          last_reg[gi]  <= prev_last;
`endif
        end
      end
    end
  endgenerate

`ifdef REDUCE_NWAY_ACCUM_EN
  // An idle accumulator behaves as the identity, so the first beat passes straight through.
  assign folded        = acc_open_reg ? op(acc_reg, data_reg[LEVELS][0], mode_reg[LEVELS])
                                      : data_reg[LEVELS][0];
  assign bus.out       = folded;
  assign bus.out_mode  = mode_reg[LEVELS];
  assign bus.out_valid = valid_reg[LEVELS] && last_reg[LEVELS];
  assign stall         = bus.out_valid && !bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_open_reg <= 1'b0;
      acc_reg      <= 1'b0;
    end else if (!stall && valid_reg[LEVELS]) begin
      if (last_reg[LEVELS]) begin
        acc_open_reg <= 1'b0;
        acc_reg      <= 1'b0;
      end else begin
        acc_open_reg <= 1'b1;
        acc_reg      <= folded;
      end
    end
  end
`else
  assign bus.out       = data_reg[LEVELS][0];
  assign bus.out_mode  = mode_reg[LEVELS];
  assign bus.out_valid = valid_reg[LEVELS];
  assign stall         = bus.out_valid && !bus.out_ready;
`endif

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Directed bench for reduce_nway_pipe: WIDTH=16 and WIDTH=5 instances on a shared clock/reset.
// Frame accumulation scenario is compiled in when REDUCE_NWAY_ACCUM_EN is defined.
module tb_reduce_nway_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reduce_nway_pipe_if #(.WIDTH(16)) bus16 ();
  reduce_nway_pipe_if #(.WIDTH(5))  bus5 ();

  reduce_nway_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  reduce_nway_pipe #(.WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5));

  task automatic drive16(input logic v, input logic [15:0] d, input logic [1:0] m);
    bus16.in_valid = v;
    bus16.in       = d;
    bus16.mode     = m;
  endtask

  task automatic drive5(input logic v, input logic [4:0] d, input logic [1:0] m);
    bus5.in_valid = v;
    bus5.in       = d;
    bus5.mode     = m;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive16(1'b1, 16'hFFFF, 2'b00);
    drive5(1'b0, 5'd0, 2'b00);
    bus16.out_ready = 1'b1;
    bus5.out_ready  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus16.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready cyc %0d got %b expected 0", c, bus16.in_ready); end
      checks++;
      if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid cyc %0d got %b expected 0", c, bus16.out_valid); end
      checks++;
      if (bus16.out !== 1'b0) begin errors++; $display("FAIL rst_out cyc %0d got %b expected 0", c, bus16.out); end
      checks++;
      if (bus16.out_mode !== 2'b00) begin errors++; $display("FAIL rst_out_mode cyc %0d got %b expected 00", c, bus16.out_mode); end
    end
    drive16(1'b0, 16'h0000, 2'b00);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b expected 1", bus16.in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_modes;
    logic [15:0] din [4];
    logic [1:0]  dmd [4];
    logic        ev  [8];
    logic        eo  [8];
    logic [1:0]  em  [8];
    din = '{16'h0000, 16'hFFFF, 16'h0007, 16'h0100};
    dmd = '{2'b00, 2'b01, 2'b10, 2'b00};
    ev  = '{0, 0, 0, 1, 1, 1, 1, 0};
    eo  = '{0, 0, 0, 0, 1, 1, 1, 0};
    em  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    bus16.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive16(1'b1, din[c], dmd[c]);
      else       drive16(1'b0, 16'h0000, 2'b00);
      #1;
      if (c < 4) begin
        checks++;
        if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL modes_in_ready cyc %0d got %b expected 1", c, bus16.in_ready); end
      end
      @(posedge clk); #1;
      checks++;
      if (bus16.out_valid !== ev[c]) begin errors++; $display("FAIL modes_valid cyc %0d got %b expected %b", c, bus16.out_valid, ev[c]); end
      if (ev[c]) begin
        checks++;
        if (bus16.out !== eo[c] || bus16.out_mode !== em[c])
          begin errors++; $display("FAIL modes_out cyc %0d got %b/%b expected %b/%b", c, bus16.out, bus16.out_mode, eo[c], em[c]); end
      end
      $display("modes cyc %0d out_valid=%b out=%b mode=%b", c, bus16.out_valid, bus16.out, bus16.out_mode);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] din [6];
    logic [1:0]  dmd [6];
    logic [2:0]  exp_beat [6];
    logic [2:0]  got [$];
    logic [2:0]  held;
    int          idx;
    din      = '{16'h0001, 16'h0003, 16'hFFFF, 16'h0000, 16'h00FF, 16'h8000};
    dmd      = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11};
    exp_beat = '{3'b100, 3'b010, 3'b101, 3'b000, 3'b010, 3'b111};
    idx  = 0;
    held = 3'b000;
    for (int c = 0; c < 20; c++) begin
      if (idx < 6) drive16(1'b1, din[idx], dmd[idx]);
      else         drive16(1'b0, 16'h0000, 2'b00);
      bus16.out_ready = !(c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 7) begin
        checks++;
        if (bus16.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid cyc %0d got %b expected 1", c, bus16.out_valid); end
        checks++;
        if (bus16.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b expected 0", c, bus16.in_ready); end
        if (c == 5) held = {bus16.out, bus16.out_mode};
        else begin
          checks++;
          if ({bus16.out, bus16.out_mode} !== held)
            begin errors++; $display("FAIL bp_hold cyc %0d got %b expected %b", c, {bus16.out, bus16.out_mode}, held); end
        end
      end
      if (bus16.out_valid === 1'b1 && bus16.out_ready === 1'b1) got.push_back({bus16.out, bus16.out_mode});
      if (bus16.in_valid === 1'b1 && bus16.in_ready === 1'b1) idx++;
      @(posedge clk); #1;
    end
    bus16.out_ready = 1'b1;
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL bp_count got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_beat[i]) begin errors++; $display("FAIL bp_beat %0d got %b expected %b", i, got[i], exp_beat[i]); end
      $display("bp beat %0d out/mode=%b", i, got[i]);
    end
  endtask

  task automatic test_width5;
    logic [4:0] din [3];
    logic [1:0] dmd [3];
    logic       ev  [6];
    logic       eo  [6];
    logic [1:0] em  [6];
    din = '{5'b11111, 5'b11110, 5'b10000};
    dmd = '{2'b01, 2'b01, 2'b10};
    ev  = '{0, 0, 1, 1, 1, 0};
    eo  = '{0, 0, 1, 0, 1, 0};
    em  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    bus5.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive5(1'b1, din[c], dmd[c]);
      else       drive5(1'b0, 5'd0, 2'b00);
      @(posedge clk); #1;
      checks++;
      if (bus5.out_valid !== ev[c]) begin errors++; $display("FAIL w5_valid cyc %0d got %b expected %b", c, bus5.out_valid, ev[c]); end
      if (ev[c]) begin
        checks++;
        if (bus5.out !== eo[c] || bus5.out_mode !== em[c])
          begin errors++; $display("FAIL w5_out cyc %0d got %b/%b expected %b/%b", c, bus5.out, bus5.out_mode, eo[c], em[c]); end
      end
      $display("w5 cyc %0d out_valid=%b out=%b mode=%b", c, bus5.out_valid, bus5.out, bus5.out_mode);
    end
  endtask

  task automatic test_reset_midflight;
    bus16.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive16(1'b1, 16'hFFFF, 2'b00);
      @(posedge clk); #1;
    end
    drive16(1'b0, 16'h0000, 2'b00);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus16.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b expected 0", bus16.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL mid_flush cyc %0d got %b expected 0", c, bus16.out_valid); end
      @(posedge clk); #1;
    end
    $display("reset_midflight done");
  endtask

`ifdef REDUCE_NWAY_ACCUM_EN
  task automatic test_accum;
    logic [15:0] din [5];
    logic [1:0]  dmd [5];
    logic        dl  [5];
    logic [2:0]  got [$];
    din = '{16'h0000, 16'h0000, 16'h0020, 16'hFFFF, 16'hFFFE};
    dmd = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    dl  = '{0, 0, 1, 0, 1};
    bus16.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 5) begin
        drive16(1'b1, din[c], dmd[c]);
        bus16.in_last = dl[c];
      end else begin
        drive16(1'b0, 16'h0000, 2'b00);
        bus16.in_last = 1'b1;
      end
      #1;
      if (bus16.out_valid === 1'b1) got.push_back({bus16.out, bus16.out_mode});
      @(posedge clk); #1;
    end
    checks++;
    if (got.size() != 2) begin errors++; $display("FAIL acc_count got %0d expected 2", got.size()); end
    if (got.size() >= 1) begin
      checks++;
      if (got[0] !== 3'b100) begin errors++; $display("FAIL acc_frame0 got %b expected 100", got[0]); end
    end
    if (got.size() >= 2) begin
      checks++;
      if (got[1] !== 3'b001) begin errors++; $display("FAIL acc_frame1 got %b expected 001", got[1]); end
    end
    $display("accum frames seen %0d", got.size());
  endtask
`endif

  initial begin
`ifdef REDUCE_NWAY_ACCUM_EN
    bus16.in_last = 1'b1;
    bus5.in_last  = 1'b1;
`endif
    test_reset();
    test_modes();
    test_backpressure();
    test_width5();
    test_reset_midflight();
`ifdef REDUCE_NWAY_ACCUM_EN
    test_accum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
